// File: rtl/div_rep_ctrl_pkg.sv
// Purpose: shared types for the repeated-subtraction divider.
// Latency: n/a (types only).
// Backpressure: n/a.
package div_pkg;

  localparam int unsigned DIV_N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/div_rep_ctrl_sub_borrow.sv
// Purpose: N-bit ripple subtractor a-b built from one-bit full-adder cells.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b (N) operands; diff (N) = a-b mod 2^N; borrow = 1 when a < b.

module sum_1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

module sub_borrow #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);
  // a - b = a + ~b + 1; the final carry is the inverse of the borrow.
  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_cell
    sum_1 u_cell (
      .a    (a[i]),
      .b    (~b[i]),
      .cin  (carry[i]),
      .s    (diff[i]),
      .cout (carry[i+1])
    );
  end

  assign borrow = ~carry[N];
endmodule

// File: rtl/div_rep_ctrl.sv
// Purpose: unsigned N-bit divider by repeated subtraction, start/busy/done handshake.
// Latency: done in cycle Q+2 after acceptance (cycle 1 for a zero divisor).
// Backpressure: none; start is ignored outside IDLE and never queued.
// Ports: clk, rst (sync, active-high); start, dividend, divisor in; busy, done,
//        quotient, remainder, div_by_zero out (all registered).

module div_rep_ctrl
  import div_pkg::*;
#(
  parameter int unsigned N = DIV_N_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  div_state_t  state_q, state_d;
  logic [N-1:0] a_reg_q, a_reg_d;
  logic [N-1:0] b_reg_q, b_reg_d;
  logic [N-1:0] q_cnt_q, q_cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N-1:0] quotient_q, quotient_d;
  logic [N-1:0] remainder_q, remainder_d;
  logic         dbz_q, dbz_d;

  logic [N-1:0] diff;
  logic         borrow;

  sub_borrow #(.N(N)) u_sub (
    .a      (a_reg_q),
    .b      (b_reg_q),
    .diff   (diff),
    .borrow (borrow)
  );

  // Results are loaded on the transition into DONE so they are already
  // visible in the done cycle.
  always_comb begin
    state_d     = state_q;
    a_reg_d     = a_reg_q;
    b_reg_d     = b_reg_q;
    q_cnt_d     = q_cnt_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_reg_d = dividend;
          b_reg_d = divisor;
          q_cnt_d = '0;
          if (divisor == '0) begin
            state_d     = DONE;
            done_d      = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
          end
        end
      end
      RUN: begin
        if (!borrow) begin
          a_reg_d = diff;
          q_cnt_d = q_cnt_q + N'(1);
          busy_d  = 1'b1;
        end else begin
          state_d     = DONE;
          done_d      = 1'b1;
          quotient_d  = q_cnt_q;
          remainder_d = a_reg_q;
          dbz_d       = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_reg_q     <= '0;
      b_reg_q     <= '0;
      q_cnt_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_reg_q     <= a_reg_d;
      b_reg_q     <= b_reg_d;
      q_cnt_q     <= q_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_rep_ctrl.sv
module tb_div_rep_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  div_rep_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int q;
    int r;
    bit dbz;
    int acc_cyc;
    int done_cyc;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   hold_q = 0;
  int   hold_r = 0;
  bit   hold_dbz = 1'b0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division; a zero divisor answers all-ones / dividend.
  function automatic exp_t model(input int a, input int b, input int acc);
    exp_t e;
    e.acc_cyc = acc;
    if (b == 0) begin
      e.q        = (1 << N) - 1;
      e.r        = a;
      e.dbz      = 1'b1;
      e.done_cyc = acc + 1;
    end else begin
      e.q        = a / b;
      e.r        = a % b;
      e.dbz      = 1'b0;
      e.done_cyc = acc + e.q + 2;
    end
    return e;
  endfunction

  // Monitor: pops the scoreboard on every done, checks busy and held outputs otherwise.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   exp_busy;
    if (mon_en) begin
      exp_busy = (sbq.size() > 0) && (cyc > sbq[0].acc_cyc) && (cyc < sbq[0].done_cyc);
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      if (done === 1'b1) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", {31'b0, done}, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("quotient", {28'b0, quotient}, e.q);
          chk("remainder", {28'b0, remainder}, e.r);
          chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e.dbz});
          chk("done_cycle", cyc, e.done_cyc);
          hold_q   = e.q;
          hold_r   = e.r;
          hold_dbz = e.dbz;
        end
      end else begin
        chk("hold_quotient", {28'b0, quotient}, hold_q);
        chk("hold_remainder", {28'b0, remainder}, hold_r);
        chk("hold_dbz", {31'b0, div_by_zero}, {31'b0, hold_dbz});
      end
    end
  end

  // Called at a negedge while the DUT is idle: the next posedge accepts.
  task automatic push_exp(input int a, input int b);
    sbq.push_back(model(a, b, cyc));
  endtask

  task automatic launch(input int a, input int b);
    start    = 1'b1;
    dividend = N'(a);
    divisor  = N'(b);
    push_exp(a, b);
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = N'($urandom);
    divisor  = N'($urandom);
  endtask

  // Returns at the negedge of the IDLE cycle that follows done.
  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 40);
    if (done !== 1'b1) begin
      chk("done_timeout", {31'b0, done}, 32'd1);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin : stim
    int ord[256];
    int a_list[6] = '{13, 3, 15, 9, 7, 6};
    int b_list[6] = '{4, 5, 1, 9, 0, 3};

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quotient", {28'b0, quotient}, 32'd0);
    chk("rst_remainder", {28'b0, remainder}, 32'd0);
    chk("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // Directed cases, including zero divisor followed by a normal one.
    for (int i = 0; i < 6; i++) begin
      launch(a_list[i], b_list[i]);
      wait_done();
    end

    // Start held high: ignored in DONE, re-triggers on the following IDLE cycle.
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd3;
    push_exp(6, 3);
    wait_done();
    push_exp(6, 3);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Start pulse in cycle 3 of a running 12/2 is ignored.
    launch(12, 2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd5;
    divisor  = 4'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done();

    // Reset in cycle 4 aborts 12/2: outputs cleared, no done pulse afterwards.
    launch(12, 2);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    hold_q   = 0;
    hold_r   = 0;
    hold_dbz = 1'b0;
    @(negedge clk);
    chk("abort_quotient", {28'b0, quotient}, 32'd0);
    chk("abort_remainder", {28'b0, remainder}, 32'd0);
    chk("abort_dbz", {31'b0, div_by_zero}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    repeat (20) @(negedge clk);

    // All 256 operand pairs in shuffled order with random idle gaps.
    for (int i = 0; i < 256; i++) ord[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j;
      int t;
      j      = int'($urandom_range(0, i));
      t      = ord[i];
      ord[i] = ord[j];
      ord[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      repeat (int'($urandom_range(0, 2))) @(negedge clk);
      launch(ord[i] >> 4, ord[i] & 15);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
